// File: rtl/conv2d_stream.sv
// Streaming KxK convolution over a raster-order pixel stream with stride, signed
// coefficients and valid/ready on both sides. Optional ReLU on the result: CONV_RELU_EN.
module conv2d_stream #(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [K*K*COEF_W-1:0]      filter,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_data,
  output logic [15:0]                out_row,
  output logic [15:0]                out_col,
  output logic                       busy,
  output logic                       frame_done,
  output logic [1:0]                 state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and a producer holds data while stalled.

  // The delay line holds the last DEPTH accepted pixels (index 0 = newest); the
  // K-1 line buffers and the window are taps into it.
  localparam int DEPTH = (K - 1) * IMG_W + K - 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                  state;
  logic [K*K*COEF_W-1:0]   coef_q;
  logic [DATA_W-1:0]       line_q [DEPTH];
  logic [15:0]             row_q, col_q, row_ph, col_ph, orow_q, ocol_q;
  logic [DATA_W-1:0]       win [K*K];
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] result;
  logic                    accept, row_end, last_px, row_hit, col_hit, emit;

  assign state_dbg = state;
  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign row_end   = (col_q == 16'(IMG_W - 1));
  assign last_px   = row_end && (row_q == 16'(IMG_H - 1));
  assign row_hit   = (row_q >= 16'(K - 1)) && (row_ph == 16'd0);
  assign col_hit   = (col_q >= 16'(K - 1)) && (col_ph == 16'd0);
  assign emit      = accept && row_hit && col_hit;

  // Window element (i,j) lies (K-1-i) rows and (K-1-j) columns behind the incoming pixel.
  for (genvar gi = 0; gi < K; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_col
      if (gi == K - 1 && gj == K - 1) begin : g_cur
        assign win[gi*K+gj] = in_data;
      end else begin : g_tap
        localparam int TAP = (K - 1 - gi) * IMG_W + (K - 1 - gj) - 1;
        assign win[gi*K+gj] = line_q[TAP];
      end
    end
  end

  always_comb begin
    logic signed [DATA_W+COEF_W:0] prod;
    prod = '0;
    sum  = '0;
    for (int n = 0; n < K * K; n++) begin
      prod = $signed({1'b0, win[n]}) * $signed(coef_q[n*COEF_W +: COEF_W]);
      sum  = sum + ACC_W'(prod);
    end
  end

`ifdef CONV_RELU_EN
  assign result = sum[ACC_W-1] ? '0 : sum;
`else
  assign result = sum;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      coef_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      row_ph     <= '0;
      col_ph     <= '0;
      orow_q     <= '0;
      ocol_q     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            coef_q <= filter;
            row_q  <= '0;
            col_q  <= '0;
            row_ph <= '0;
            col_ph <= '0;
            orow_q <= '0;
            ocol_q <= '0;
            busy   <= 1'b1;
            state  <= RUN;
            for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            line_q[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
            if (emit) begin
              out_data  <= result;
              out_row   <= orow_q;
              out_col   <= ocol_q;
              out_valid <= 1'b1;
              ocol_q    <= ocol_q + 16'd1;
            end
            // Phase counters replace the modulo-STRIDE tests; they only run once
            // the index has reached the first full window position.
            if (row_end) begin
              col_q  <= '0;
              col_ph <= '0;
              ocol_q <= '0;
              row_q  <= row_q + 16'd1;
              if (row_q >= 16'(K - 1))
                row_ph <= (row_ph == 16'(STRIDE - 1)) ? 16'd0 : row_ph + 16'd1;
              if (row_hit) orow_q <= orow_q + 16'd1;
            end else begin
              col_q <= col_q + 16'd1;
              if (col_q >= 16'(K - 1))
                col_ph <= (col_ph == 16'(STRIDE - 1)) ? 16'd0 : col_ph + 16'd1;
            end
            if (last_px) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!out_valid || out_ready) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Randomised bench for conv2d_stream: a stride-1 and a stride-2 instance checked
// against a direct-convolution model of the frame.
module tb_conv2d_stream;

  localparam int IMG_W  = 5;
  localparam int IMG_H  = 5;
  localparam int K      = 3;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int ACC_W  = 20;
  localparam int N      = IMG_W * IMG_H;
  localparam int EW     = ACC_W + 32;
  localparam int BUDGET = 3000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                  start = 1'b0;
  logic [K*K*COEF_W-1:0] filter = '0;
  logic                  in_valid = 1'b0;
  logic [DATA_W-1:0]     in_data = '0;
  logic                  out_ready = 1'b0;
  logic                  sel = 1'b0;

  logic start_a, start_b, in_valid_a, in_valid_b, out_ready_a, out_ready_b;
  logic in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic busy_a, busy_b, frame_done_a, frame_done_b;
  logic [ACC_W-1:0] out_data_a, out_data_b;
  logic [15:0] out_row_a, out_row_b, out_col_a, out_col_b;
  logic [1:0] state_dbg_a, state_dbg_b;

  logic in_ready, out_valid, busy, frame_done;
  logic [ACC_W-1:0] out_data;
  logic [15:0] out_row, out_col;
  logic [1:0] state_dbg;

  assign start_a     = start && !sel;
  assign start_b     = start && sel;
  assign in_valid_a  = in_valid && !sel;
  assign in_valid_b  = in_valid && sel;
  assign out_ready_a = out_ready && !sel;
  assign out_ready_b = out_ready && sel;
  assign in_ready    = sel ? in_ready_b   : in_ready_a;
  assign out_valid   = sel ? out_valid_b  : out_valid_a;
  assign busy        = sel ? busy_b       : busy_a;
  assign frame_done  = sel ? frame_done_b : frame_done_a;
  assign out_data    = sel ? out_data_b   : out_data_a;
  assign out_row     = sel ? out_row_b    : out_row_a;
  assign out_col     = sel ? out_col_b    : out_col_a;
  assign state_dbg   = sel ? state_dbg_b  : state_dbg_a;

  conv2d_stream #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .STRIDE(1), .DATA_W(DATA_W),
                  .COEF_W(COEF_W), .ACC_W(ACC_W)) u_s1 (
    .clk(clk), .rst(rst), .start(start_a), .filter(filter),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_row(out_row_a), .out_col(out_col_a), .busy(busy_a),
    .frame_done(frame_done_a), .state_dbg(state_dbg_a)
  );

  conv2d_stream #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .STRIDE(2), .DATA_W(DATA_W),
                  .COEF_W(COEF_W), .ACC_W(ACC_W)) u_s2 (
    .clk(clk), .rst(rst), .start(start_b), .filter(filter),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_row(out_row_b), .out_col(out_col_b), .busy(busy_b),
    .frame_done(frame_done_b), .state_dbg(state_dbg_b)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  int pix [N];
  int coef [K*K];
  logic [EW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: direct convolution at every stride-reachable window origin.
  function automatic void build_expected(input int stride);
    int oh, ow, s;
    exp_q.delete();
    oh = (IMG_H - K) / stride + 1;
    ow = (IMG_W - K) / stride + 1;
    for (int orow = 0; orow < oh; orow++)
      for (int ocol = 0; ocol < ow; ocol++) begin
        s = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            s += pix[(orow*stride + i)*IMG_W + ocol*stride + j] * coef[i*K + j];
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        exp_q.push_back({16'(orow), 16'(ocol), ACC_W'(s)});
      end
  endfunction

  // driver tasks
  task automatic load_filter();
    for (int i = 0; i < K*K; i++) filter[i*COEF_W +: COEF_W] = COEF_W'(coef[i]);
  endtask

  task automatic ramp_image();
    for (int i = 0; i < N; i++) pix[i] = i;
  endtask

  task automatic fill_coef(input int v);
    for (int i = 0; i < K*K; i++) coef[i] = v;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 0);
    check({tag, "_out_valid"}, 64'(out_valid), 0);
    check({tag, "_out_data"}, 64'(out_data), 0);
    check({tag, "_out_row"}, 64'(out_row), 0);
    check({tag, "_out_col"}, 64'(out_col), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_frame_done"}, 64'(frame_done), 0);
  endtask

  task automatic run_frame(input bit vmode, input bit rmode, input bit stall, input bit poke);
    int  done_cnt = 0;
    int  taken = 0;
    int  received = 0;
    int  total;
    build_expected(sel ? 2 : 1);
    total = exp_q.size();
    load_filter();
    pulse_start();
    check("busy_after_start", 64'(busy), 1);
    fork
      begin : drive
        int guard = 0;
        while (taken < N && guard < BUDGET) begin
          in_valid = vmode ? ($urandom_range(0, 3) != 0) : 1'b1;
          in_data  = DATA_W'(pix[taken]);
          @(negedge clk);
          if (in_valid && in_ready) taken++;
          @(posedge clk); #1;
          guard++;
        end
        in_valid = 1'b0;
      end
      begin : monitor
        int guard = 0;
        int stalled = 0;
        logic [EW-1:0] e;
        out_ready = stall ? 1'b0 : 1'b1;
        while (!(exp_q.size() == 0 && done_cnt > 0) && guard < BUDGET) begin
          @(negedge clk);
          if (frame_done) begin
            done_cnt++;
            check("done_early", 64'(exp_q.size()), 0);
          end
          if (stall && out_valid && stalled < 5 && exp_q.size() > 0) begin
            check("stall_in_ready", 64'(in_ready), 0);
            check("stall_hold", 64'(out_data), 64'(exp_q[0][ACC_W-1:0]));
            stalled++;
          end
          if (out_valid && out_ready) begin
            received++;
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("out_data", 64'(out_data), 64'(e[ACC_W-1:0]));
              check("out_col", 64'(out_col), 64'(e[ACC_W +: 16]));
              check("out_row", 64'(out_row), 64'(e[ACC_W+16 +: 16]));
            end
          end
          @(posedge clk); #1;
          guard++;
          out_ready = stall ? (stalled >= 5) : (rmode ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        check("frame_timeout", 64'(guard >= BUDGET), 0);
        out_ready = 1'b0;
      end
      begin : poker
        if (poke) begin
          repeat (6) @(posedge clk);
          #1 filter = ~filter;
          start = 1'b1;
          @(posedge clk); #1 start = 1'b0;
          load_filter();
          check("busy_poke", 64'(busy), 1);
        end
      end
    join
    repeat (3) begin
      @(negedge clk);
      if (frame_done) done_cnt++;
    end
    check("pixels_taken", 64'(taken), 64'(N));
    check("out_count", 64'(received), 64'(total));
    check("done_count", 64'(done_cnt), 1);
    check("busy_end", 64'(busy), 0);
    check("state_idle", 64'(state_dbg), 0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; #1 check_idle("rst_s1");
    sel = 1'b1; #1 check_idle("rst_s2");
    rst = 1'b1;

    // ramp image, unit kernel, stride 1 then stride 2
    ramp_image(); fill_coef(1);
    sel = 1'b0; run_frame(0, 0, 0, 0);
    sel = 1'b1; run_frame(0, 0, 0, 0);

    // negative kernel exercises signed accumulation (and ReLU if built in)
    fill_coef(-1);
    sel = 1'b0; run_frame(0, 0, 0, 0);

    // output stall right after the first result
    fill_coef(1);
    run_frame(0, 0, 1, 0);

    // reset in the middle of a frame fed with junk pixels
    load_filter();
    pulse_start();
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = DATA_W'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b0; #1;
    check_idle("midrst");
    @(posedge clk); #1 rst = 1'b1;
    run_frame(0, 0, 0, 0);

    // start during RUN with another filter must be ignored
    for (int i = 0; i < K*K; i++) coef[i] = i - 4;
    run_frame(0, 0, 0, 1);

    // random frames with random flow control on both instances
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) pix[i] = int'($urandom_range(0, 255));
      for (int i = 0; i < K*K; i++) coef[i] = int'($urandom_range(0, 255)) - 128;
      sel = 1'(t % 2);
      run_frame(1, 1, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
